// File: rtl/out_port_arbiter.sv
// out_port_arbiter: one crossbar output of the 5-port mesh router.
// Grants the output to one input per packet in round-robin order, holds
// the grant from HEADER to TAIL, and paces FIFO reads against downstream
// credits.
//
// Handshake: an input is served only while it is granted; a flit moves on
// every cycle where rd_en[g] is high (FIFO non-empty and a credit is
// available), and shows up on the crossbar one cycle later with out_valid.
module out_port_arbiter #(
   parameter int CREDITS = 4,
   parameter int CW      = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    req,
   input  logic [4:0]    empty,
   input  logic [14:0]   flit_id,
   input  logic          credit_in,
   output logic [4:0]    grant,
   output logic [4:0]    rd_en,
   output logic [2:0]    xbar_sel,
   output logic          out_valid,
   output logic          credit_err
);

   localparam logic [2:0] HEADER = 3'b001;
   localparam logic [2:0] TAIL   = 3'b100;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [4:0]    grant_q, grant_d;
   logic [2:0]    sel_q, sel_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] credits_q, credits_d;
   logic          out_valid_q, out_valid_d;
   logic          credit_err_q, credit_err_d;

   logic [4:0]    elig;
   logic          pick_found;
   logic [2:0]    pick_idx;
   logic [3:0]    cand_sum;
   logic [2:0]    cand;
   logic [2:0]    g_flit;
   logic          rd_any;

   // Eligible inputs: requesting, data present, and a HEADER at the FIFO head.
   always_comb begin
      elig = '0;
      for (int i = 0; i < 5; i++) begin
         elig[i] = req[i] & ~empty[i] & (flit_id[3*i +: 3] == HEADER);
      end
   end

   // Round-robin pick: first eligible index after the last-served pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_sum   = '0;
      cand       = '0;
      for (int k = 1; k <= 5; k++) begin
         cand_sum = {1'b0, ptr_q} + 4'(k);
         if (cand_sum >= 4'd5) cand_sum = cand_sum - 4'd5;
         cand = cand_sum[2:0];
         if (!pick_found && elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Read strobe for the granted input and the type of the flit being read.
   always_comb begin
      rd_en  = '0;
      g_flit = '0;
      if (state_q == BUSY && credits_q != '0) begin
         rd_en = grant_q & ~empty;
      end
      for (int i = 0; i < 5; i++) begin
         if (grant_q[i]) g_flit = flit_id[3*i +: 3];
      end
      rd_any = |rd_en;
   end

   // Next-state logic: arbitration FSM, credit counter and error flag.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      sel_d        = sel_q;
      ptr_d        = ptr_q;
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      out_valid_d  = rd_any;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = 5'b00001 << pick_idx;
               sel_d   = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // The lock is released only by a TAIL that is actually read.
            if (rd_any && g_flit == TAIL) begin
               state_d = IDLE;
               ptr_d   = sel_q;
               grant_d = '0;
               sel_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      unique case ({rd_any, credit_in})
         2'b10: credits_d = credits_q - CW'(1);
         2'b01: begin
            if (credits_q == CW'(CREDITS)) credit_err_d = 1'b1;
            else                           credits_d    = credits_q + CW'(1);
         end
         default: credits_d = credits_q;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         sel_q        <= '0;
         ptr_q        <= 3'd4;
         credits_q    <= CW'(CREDITS);
         out_valid_q  <= 1'b0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         sel_q        <= sel_d;
         ptr_q        <= ptr_d;
         credits_q    <= credits_d;
         out_valid_q  <= out_valid_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign grant      = grant_q;
   assign xbar_sel   = sel_q;
   assign out_valid  = out_valid_q;
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Testbench for out_port_arbiter: models five input FIFOs, checks every
// flit read against an expected queue, and checks out_valid every cycle.
module tb_out_port_arbiter;

   localparam int CREDITS = 4;
   localparam int CW      = 3;
   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] PAY = 3'b010;
   localparam logic [2:0] TL  = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  req = '0;
   logic [4:0]  empty = '1;
   logic [14:0] flit_id = '0;
   logic        credit_in = 1'b0;
   logic [4:0]  grant;
   logic [4:0]  rd_en;
   logic [2:0]  xbar_sel;
   logic        out_valid;
   logic        credit_err;

   always #5 clk = ~clk;

   out_port_arbiter #(.CREDITS(CREDITS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .empty(empty), .flit_id(flit_id),
      .credit_in(credit_in), .grant(grant), .rd_en(rd_en),
      .xbar_sel(xbar_sel), .out_valid(out_valid), .credit_err(credit_err)
   );

   logic [2:0] fmem [5][16];
   int         rp [5];
   int         wp [5];
   logic [5:0] exp_q [$];
   int         errors = 0;
   int         checks = 0;
   int         cycles = 0;
   bit         auto_credit = 0;

   task automatic drive_inputs();
      for (int i = 0; i < 5; i++) begin
         empty[i] = (rp[i] == wp[i]);
         flit_id[3*i +: 3] = (rp[i] == wp[i]) ? 3'b000 : fmem[i][rp[i] % 16];
      end
   endtask

   // Queue a packet on input idx and record its flits as expected reads.
   task automatic push_pkt(input int idx, input int len);
      logic [2:0] t;
      for (int k = 0; k < len; k++) begin
         t = (k == 0) ? HDR : ((k == len - 1) ? TL : PAY);
         fmem[idx][wp[idx] % 16] = t;
         wp[idx]++;
         exp_q.push_back({3'(idx), t});
      end
      req[idx] = 1'b1;
      drive_inputs();
   endtask

   // One clock cycle: score the read happening now, advance, pop the FIFO.
   task automatic tick();
      logic [4:0] rd_pre;
      logic       rst_pre;
      logic [5:0] e;
      logic [5:0] got;
      logic       exp_ov;
      int         idx_i;
      bit         did_read;
      rd_pre   = rd_en;
      rst_pre  = rst;
      idx_i    = 0;
      did_read = 0;
      if (rst_pre && rd_pre != 5'b0) begin
         did_read = 1;
         for (int i = 0; i < 5; i++) if (rd_pre[i]) idx_i = i;
         got = {3'(idx_i), fmem[idx_i][rp[idx_i] % 16]};
         checks++;
         if (!$onehot(rd_pre) || exp_q.size() == 0 || rp[idx_i] == wp[idx_i]) begin
            errors++;
            $display("FAIL read_sb: rd_en=%b expected_left=%0d", rd_pre, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL read_sb: got input %0d type %b, want input %0d type %b",
                        got[5:3], got[2:0], e[5:3], e[2:0]);
            end
         end
      end
      @(posedge clk);
      #1;
      cycles++;
      if (did_read) rp[idx_i]++;
      credit_in = auto_credit & out_valid;
      drive_inputs();
      exp_ov = rst_pre & (rd_pre != 5'b0);
      checks++;
      if (out_valid !== exp_ov) begin
         errors++;
         $display("FAIL out_valid: got %b want %b at cycle %0d", out_valid, exp_ov, cycles);
      end
      if (cycles > 20000) begin
         $display("FAIL watchdog: cycle budget exhausted");
         $fatal(1, "watchdog");
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      credit_in = 1'b0;
      auto_credit = 0;
      for (int i = 0; i < 5; i++) begin rp[i] = 0; wp[i] = 0; end
      exp_q.delete();
      drive_inputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b want 00000", grant); end
      checks++;
      if (rd_en !== 5'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 00000", rd_en); end
      checks++;
      if (xbar_sel !== 3'd0) begin errors++; $display("FAIL reset_xbar_sel: got %0d want 0", xbar_sel); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b want 0", credit_err); end
   endtask

   task automatic test_single_packet();
      do_reset();
      push_pkt(1, 3);
      tick(); // cycle 1
      checks++;
      if (grant !== 5'b00010) begin errors++; $display("FAIL single_grant: got %b want 00010", grant); end
      checks++;
      if (xbar_sel !== 3'd1) begin errors++; $display("FAIL single_sel: got %0d want 1", xbar_sel); end
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (rd_en !== 5'b00010) begin
            errors++; $display("FAIL single_rd_en: cycle %0d got %b want 00010", c, rd_en);
         end
         tick();
      end
      // cycle 4
      checks++;
      if (grant !== 5'b0 || rd_en !== 5'b0) begin
         errors++; $display("FAIL single_release: grant %b rd_en %b want 00000", grant, rd_en);
      end
      tick();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_round_robin();
      int n;
      do_reset();
      auto_credit = 1;
      push_pkt(0, 2);
      push_pkt(2, 2);
      push_pkt(4, 2);
      n = 0;
      while (grant !== 5'b10000 && n < 60) begin tick(); n++; end
      checks++;
      if (grant !== 5'b10000) begin errors++; $display("FAIL rr_reach4: got %b want 10000", grant); end
      push_pkt(0, 2);
      n = 0;
      while ((exp_q.size() != 0 || grant !== 5'b0) && n < 60) begin tick(); n++; end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_credit_stall();
      int nreads;
      do_reset();
      push_pkt(2, 6);
      tick(); // cycle 1
      checks++;
      if (grant !== 5'b00100) begin errors++; $display("FAIL stall_grant: got %b want 00100", grant); end
      nreads = 0;
      for (int k = 0; k < 6; k++) begin
         if (rd_en != 5'b0) nreads++;
         tick();
      end
      checks++;
      if (nreads != CREDITS) begin errors++; $display("FAIL stall_reads: got %0d want %0d", nreads, CREDITS); end
      checks++;
      if (rd_en !== 5'b0 || grant !== 5'b00100) begin
         errors++; $display("FAIL stall_hold: rd_en %b grant %b want 00000/00100", rd_en, grant);
      end
      credit_in = 1'b1;
      tick();
      checks++;
      if (rd_en !== 5'b00100) begin errors++; $display("FAIL stall_one_credit: got %b want 00100", rd_en); end
      tick();
      checks++;
      if (rd_en !== 5'b0) begin errors++; $display("FAIL stall_again: got %b want 00000", rd_en); end
      credit_in = 1'b1;
      tick();
      tick();
      checks++;
      if (grant !== 5'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL stall_finish: grant %b left %0d want 00000/0", grant, exp_q.size());
      end
   endtask

   task automatic test_lock();
      int n;
      do_reset();
      auto_credit = 1;
      push_pkt(3, 4);
      tick(); // cycle 1
      checks++;
      if (grant !== 5'b01000) begin errors++; $display("FAIL lock_grant: got %b want 01000", grant); end
      push_pkt(1, 2);
      for (int c = 2; c <= 4; c++) begin
         tick();
         req[3] = 1'b0;
         checks++;
         if (grant !== 5'b01000) begin
            errors++; $display("FAIL lock_hold: cycle %0d got %b want 01000", c, grant);
         end
      end
      tick(); // cycle 5: dead cycle after TAIL
      checks++;
      if (grant !== 5'b0) begin errors++; $display("FAIL lock_dead: got %b want 00000", grant); end
      tick(); // cycle 6
      checks++;
      if (grant !== 5'b00010 || xbar_sel !== 3'd1) begin
         errors++; $display("FAIL lock_next: grant %b sel %0d want 00010/1", grant, xbar_sel);
      end
      n = 0;
      while ((exp_q.size() != 0 || grant !== 5'b0) && n < 40) begin tick(); n++; end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL lock_drain: %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_credit_err();
      int nreads;
      do_reset();
      credit_in = 1'b1;
      tick();
      checks++;
      if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", credit_err); end
      push_pkt(4, 5);
      nreads = 0;
      for (int k = 0; k < 8; k++) begin
         if (rd_en != 5'b0) nreads++;
         tick();
      end
      checks++;
      if (nreads != CREDITS) begin errors++; $display("FAIL err_saturate: reads %0d want %0d", nreads, CREDITS); end
      checks++;
      if (credit_err !== 1'b1 || grant !== 5'b10000) begin
         errors++; $display("FAIL err_sticky: err %b grant %b want 1/10000", credit_err, grant);
      end
      do_reset();
      checks++;
      if (credit_err !== 1'b0 || grant !== 5'b0 || rd_en !== 5'b0) begin
         errors++; $display("FAIL err_reset: err %b grant %b rd_en %b want 0/00000/00000",
                            credit_err, grant, rd_en);
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_credit_stall();
      test_lock();
      test_credit_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port packet arbiter for the 5-port mesh router. It sits between the five input-port LBDR route units and one crossbar output, one instance per output (N, E, W, S, L). It grants the output to one requesting input per packet in round-robin order and holds the grant from HEADER to TAIL. It also paces flit reads from the granted input FIFO against a downstream credit counter.

## Interface
- `CREDITS`, default 4: downstream buffer depth; reset and maximum value of the credit counter.
- `CW`, default 3: credit counter width; must hold `CREDITS`.
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `req`, input, 5: bit i means input i's route unit selects this output. Index order: 0=N, 1=E, 2=W, 3=S, 4=L.
- `empty`, input, 5: bit i means input i's FIFO is empty.
- `flit_id`, input, 15: head-flit type of input i on bits [3i+2:3i]. Codes from the shared parameters include: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
- `credit_in`, input, 1: one-cycle pulse; downstream freed one buffer slot.
- `grant`, output, 5: one-hot registered grant, or 0.
- `rd_en`, output, 5: combinational FIFO read strobe, at most one bit set.
- `xbar_sel`, output, 3: binary index of the granted input; 0 when none.
- `out_valid`, output, 1: registered; a flit appears on the crossbar output this cycle.
- `credit_err`, output, 1: sticky; set when `credit_in` arrives with the counter already at `CREDITS`.

## Operation
- Reset (`rst`=0 at a rising edge) sets:
  - state=IDLE, `grant`=0, `xbar_sel`=0, `out_valid`=0, `credit_err`=0
  - credits=`CREDITS`, round-robin pointer=4, so input 0 has the highest priority first.
  - The outputs hold these values until the first edge with `rst`=1.
- Eligibility: input i is eligible when `req`[i] & ~`empty`[i] & (`flit_id`[i]==HEADER).
- IDLE:
  - If any input is eligible, select the first eligible index scanning ptr+1, ptr+2, … modulo 5.
  - Register `grant` one-hot and `xbar_sel`, then go to BUSY.
  - Otherwise stay in IDLE.
  - Granting does not require credits.
- BUSY, with g as the granted index:
  - `rd_en`[g] = ~`empty`[g] & (credits != 0). All other `rd_en` bits are 0.
  - Each cycle with `rd_en`[g]=1 forwards one flit.
  - If the forwarded flit's `flit_id`[g]==TAIL: next state is IDLE, ptr←g, `grant`←0, `xbar_sel`←0.
  - The lock ignores `req`; deasserting `req`[g] mid-packet does not release the grant.
  - A HEADER arriving on g while BUSY is forwarded as an ordinary flit; there is no release without TAIL.
- IDLE never asserts `rd_en`.
- Credits:
  - Decrement on `rd_en`≠0.
  - Increment on `credit_in`.
  - Both in the same cycle: unchanged.
  - `credit_in` at `CREDITS` with no read: counter stays at `CREDITS` and `credit_err`←1.
  - The counter never underflows, because `rd_en` is gated by credits≠0.
- `out_valid` ← |`rd_en` (one-cycle registered FIFO read latency).
- FSM: two states, IDLE and BUSY. Transitions:
  - IDLE→BUSY on any eligible input.
  - BUSY→IDLE on a TAIL read.
  - Any state→IDLE on reset.

## Timing
- Request-to-grant latency:
  - Eligible at cycle 0 in IDLE → `grant` visible in cycle 1.
  - First `rd_en` in cycle 1 if credits>0.
  - `out_valid` in cycle 2.
- Throughput: one flit per cycle while the FIFO is non-empty and credits remain.
- TAIL read in cycle t → `grant`=0 in cycle t+1 (IDLE). A new grant is visible in cycle t+2 at the earliest, so there is one dead cycle between packets.
- Empty FIFO mid-packet: stall with the grant held, no `rd_en`.
- Credits at 0: stall. A `credit_in` in cycle t allows `rd_en` in cycle t+1.
- Reset mid-packet: grant dropped at the next edge; the partial packet is discarded by the upstream flush.

## Test plan
- Reset with `rst`=0 for 2 cycles → `grant`=0, `rd_en`=0, `out_valid`=0, `credit_err`=0. With CREDITS=4, four reads are possible without any `credit_in`.
- Single packet: input 1 requests with HEADER, PAYLOAD, TAIL queued, CREDITS=4 → `grant`=5'b00010 in cycle 1, `xbar_sel`=1, `rd_en`[1] high in cycles 1–3, `out_valid` high in cycles 2–4, `grant`=0 in cycle 4.
- Round-robin: inputs 0, 2 and 4 hold 2-flit packets simultaneously → grant order 0, 2, 4. A fresh input 0 request arriving while 4 is served is granted after 4.
- Credit stall: CREDITS=4, 6-flit packet, no `credit_in` → four reads, then `rd_en`=0 with the grant held. One `credit_in` pulse → exactly one more read the next cycle.
- Lock and error:
  - Deassert `req`[3] after the HEADER of input 3's packet → the grant persists until TAIL.
  - `credit_in` pulsed at full credits → `credit_err`=1 and stays set until reset.
